// File: rtl/cpu_pkg.sv
// Shared encodings for the LEGv8-subset decode/execute slice: opcodes, ALU ops, operand-B selects.
package cpu_pkg;

  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [4:0]  COND_LT = 5'h0B;

  localparam logic [2:0]  ALU_PASS_B = 3'b000;
  localparam logic [2:0]  ALU_ADD    = 3'b010;
  localparam logic [2:0]  ALU_SUB    = 3'b011;
  localparam logic [2:0]  ALU_AND    = 3'b100;
  localparam logic [2:0]  ALU_OR     = 3'b101;
  localparam logic [2:0]  ALU_XOR    = 3'b110;

  localparam logic [1:0]  SRC_REG    = 2'b00;
  localparam logic [1:0]  SRC_DADDR9 = 2'b01;
  localparam logic [1:0]  SRC_IMM12  = 2'b10;
  localparam logic [1:0]  SRC_ZERO   = 2'b11;

  typedef struct packed {
    logic       reg2loc;
    logic [1:0] alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       use_shift;
    logic       set_flag;
    logic       br_taken;
    logic       uncond_br;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/alu64.sv
// Purely combinational 64-bit ALU with N/Z/V/C; C and V are only meaningful for add/sub.
module alu64
  import cpu_pkg::*;
(
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic [2:0]  i_op,
  output logic [63:0] o_result,
  output logic        o_n,
  output logic        o_z,
  output logic        o_v,
  output logic        o_c
);

  logic        w_sub;
  logic        w_arith;
  logic [63:0] w_b_eff;
  logic [64:0] w_sum;

  assign w_sub   = (i_op == ALU_SUB);
  assign w_arith = (i_op == ALU_ADD) || w_sub;
  // Subtraction is A + ~B + 1 so carry means "no borrow".
  assign w_b_eff = w_sub ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {64'd0, w_sub};

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_PASS_B: o_result = i_b;
      ALU_ADD,
      ALU_SUB:    o_result = w_sum[63:0];
      ALU_AND:    o_result = i_a & i_b;
      ALU_OR:     o_result = i_a | i_b;
      ALU_XOR:    o_result = i_a ^ i_b;
      default:    o_result = '0;
    endcase
  end

  assign o_n = o_result[63];
  assign o_z = (o_result == 64'd0);
  assign o_c = w_arith & w_sum[64];
  assign o_v = w_arith & (i_a[63] == w_b_eff[63]) & (w_sum[63] != i_a[63]);

endmodule

// File: rtl/decode_execute_core.sv
// Single-cycle LEGv8-subset decode + 64-bit execute with registered N/Z/V/C.
// All outputs except the flag register are combinational; flags update on the edge after set_flag.
module decode_execute_core
  import cpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_instruction,
  input  logic [63:0] i_read_data1,
  input  logic [63:0] i_read_data2,
  output logic        o_reg2loc,
  output logic [1:0]  o_alu_src,
  output logic        o_mem_to_reg,
  output logic        o_reg_write,
  output logic        o_mem_write,
  output logic        o_use_shift,
  output logic        o_set_flag,
  output logic        o_br_taken,
  output logic        o_uncond_br,
  output logic [2:0]  o_alu_op,
  output logic [63:0] o_alu_result,
  output logic        o_alu_n,
  output logic        o_alu_z,
  output logic        o_alu_v,
  output logic        o_alu_c,
  output logic        o_flag_n,
  output logic        o_flag_z,
  output logic        o_flag_v,
  output logic        o_flag_c
);

  ctrl_t       w_ctrl;
  logic        w_is_cbz;
  logic        w_is_blt;
  logic [63:0] w_operand_b;
  logic [3:0]  r_flags;
  logic        w_unused_bits;

  // Branch conditions are resolved outside the decode block so decode never depends on ALU output.
  always_comb begin
    w_ctrl   = '0;
    w_is_cbz = 1'b0;
    w_is_blt = 1'b0;
    if (i_instruction[31:21] == OP_ADDS || i_instruction[31:21] == OP_SUBS) begin
      w_ctrl.reg2loc   = 1'b1;
      w_ctrl.alu_src   = SRC_REG;
      w_ctrl.alu_op    = (i_instruction[31:21] == OP_SUBS) ? ALU_SUB : ALU_ADD;
      w_ctrl.reg_write = 1'b1;
      w_ctrl.set_flag  = 1'b1;
    end else if (i_instruction[31:21] == OP_AND || i_instruction[31:21] == OP_EOR) begin
      w_ctrl.reg2loc   = 1'b1;
      w_ctrl.alu_op    = (i_instruction[31:21] == OP_EOR) ? ALU_XOR : ALU_AND;
      w_ctrl.reg_write = 1'b1;
    end else if (i_instruction[31:21] == OP_LSR) begin
      w_ctrl.use_shift = 1'b1;
      w_ctrl.reg_write = 1'b1;
      w_ctrl.alu_op    = ALU_PASS_B;
    end else if (i_instruction[31:21] == OP_LDUR) begin
      w_ctrl.alu_src    = SRC_DADDR9;
      w_ctrl.alu_op     = ALU_ADD;
      w_ctrl.mem_to_reg = 1'b1;
      w_ctrl.reg_write  = 1'b1;
    end else if (i_instruction[31:21] == OP_STUR) begin
      w_ctrl.alu_src   = SRC_DADDR9;
      w_ctrl.alu_op    = ALU_ADD;
      w_ctrl.mem_write = 1'b1;
    end else if (i_instruction[31:22] == OP_ADDI) begin
      w_ctrl.alu_src   = SRC_IMM12;
      w_ctrl.alu_op    = ALU_ADD;
      w_ctrl.reg_write = 1'b1;
    end else if (i_instruction[31:24] == OP_BCOND) begin
      w_is_blt = (i_instruction[4:0] == COND_LT);
    end else if (i_instruction[31:24] == OP_CBZ) begin
      w_ctrl.alu_src = SRC_REG;
      w_ctrl.alu_op  = ALU_PASS_B;
      w_is_cbz       = 1'b1;
    end else if (i_instruction[31:26] == OP_B) begin
      w_ctrl.br_taken  = 1'b1;
      w_ctrl.uncond_br = 1'b1;
    end
  end

  always_comb begin
    w_operand_b = '0;
    case (w_ctrl.alu_src)
      SRC_REG:    w_operand_b = i_read_data2;
      SRC_DADDR9: w_operand_b = {{55{i_instruction[20]}}, i_instruction[20:12]};
      SRC_IMM12:  w_operand_b = {52'd0, i_instruction[21:10]};
      default:    w_operand_b = '0;
    endcase
  end

  alu64 u_alu (
    .i_a      (i_read_data1),
    .i_b      (w_operand_b),
    .i_op     (w_ctrl.alu_op),
    .o_result (o_alu_result),
    .o_n      (o_alu_n),
    .o_z      (o_alu_z),
    .o_v      (o_alu_v),
    .o_c      (o_alu_c)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_flags <= 4'b0000;
    end else if (w_ctrl.set_flag) begin
      r_flags <= {o_alu_n, o_alu_z, o_alu_v, o_alu_c};
    end
  end

  assign {o_flag_n, o_flag_z, o_flag_v, o_flag_c} = r_flags;

  assign o_reg2loc    = w_ctrl.reg2loc;
  assign o_alu_src    = w_ctrl.alu_src;
  assign o_mem_to_reg = w_ctrl.mem_to_reg;
  assign o_reg_write  = w_ctrl.reg_write;
  assign o_mem_write  = w_ctrl.mem_write;
  assign o_use_shift  = w_ctrl.use_shift;
  assign o_set_flag   = w_ctrl.set_flag;
  assign o_alu_op     = w_ctrl.alu_op;
  assign o_uncond_br  = w_ctrl.uncond_br;
  assign o_br_taken   = w_ctrl.br_taken | (w_is_cbz & o_alu_z) |
                        (w_is_blt & (r_flags[3] ^ r_flags[1]));

  assign w_unused_bits = ^i_instruction[9:5];

endmodule

// File: tb/tb_decode_execute_core.sv
// Directed-vector bench for decode_execute_core with a queue-based scoreboard checked on the falling edge.
module tb_decode_execute_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [63:0] rd1, rd2;

  logic        reg2loc, mem_to_reg, reg_write, mem_write, use_shift, set_flag, br_taken, uncond_br;
  logic [1:0]  alu_src;
  logic [2:0]  alu_op;
  logic [63:0] alu_result;
  logic        alu_n, alu_z, alu_v, alu_c, flag_n, flag_z, flag_v, flag_c;

  always #5 clk = ~clk;

  decode_execute_core dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_instruction(instr),
    .i_read_data1(rd1), .i_read_data2(rd2),
    .o_reg2loc(reg2loc), .o_alu_src(alu_src), .o_mem_to_reg(mem_to_reg),
    .o_reg_write(reg_write), .o_mem_write(mem_write), .o_use_shift(use_shift),
    .o_set_flag(set_flag), .o_br_taken(br_taken), .o_uncond_br(uncond_br),
    .o_alu_op(alu_op), .o_alu_result(alu_result),
    .o_alu_n(alu_n), .o_alu_z(alu_z), .o_alu_v(alu_v), .o_alu_c(alu_c),
    .o_flag_n(flag_n), .o_flag_z(flag_z), .o_flag_v(flag_v), .o_flag_c(flag_c)
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [12:0] ctrl;
    logic [63:0] res;
    logic [3:0]  af;
    logic [3:0]  ff;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_pop    = 0;
  logic chk_vld  = 1'b0;

  wire [12:0] dut_ctrl = {reg2loc, alu_src, mem_to_reg, reg_write, mem_write,
                          use_shift, set_flag, br_taken, uncond_br, alu_op};

  function automatic logic [12:0] cv(input logic r2l, input logic [1:0] src, input logic m2r,
                                     input logic rw, input logic mw, input logic us, input logic sf,
                                     input logic bt, input logic ub, input logic [2:0] op);
    return {r2l, src, m2r, rw, mw, us, sf, bt, ub, op};
  endfunction

  function automatic exp_t mk(input logic [7:0] id, input logic [12:0] c, input logic [63:0] r,
                              input logic [3:0] af, input logic [3:0] ff);
    exp_t e;
    e.id = id; e.ctrl = c; e.res = r; e.af = af; e.ff = ff;
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] id, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_vld) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got empty queue expected an entry");
      end else begin
        e = sb_q.pop_front();
        n_pop++;
        check("ctrl",      e.id, {51'd0, dut_ctrl}, {51'd0, e.ctrl});
        check("result",    e.id, alu_result, e.res);
        check("alu_nzvc",  e.id, {60'd0, alu_n, alu_z, alu_v, alu_c}, {60'd0, e.af});
        check("flag_nzvc", e.id, {60'd0, flag_n, flag_z, flag_v, flag_c}, {60'd0, e.ff});
      end
    end
  end

  task automatic apply(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                       input logic rst_lvl, input logic drop, input exp_t e);
    @(posedge clk);
    #1;
    rst_n = rst_lvl;
    instr = ins;
    rd1   = a;
    rd2   = b;
    sb_q.push_back(e);
    n_push++;
    chk_vld = 1'b1;
    if (drop) begin
      #2;
      rst_n = 1'b0;
    end
  endtask

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic [31:0] i_adds, i_subs, i_and, i_eor, i_addi, i_blt, i_beq;
    logic [31:0] i_ldur, i_stur, i_cbz, i_b, i_lsr;
    logic [12:0] c_adds, c_subs;

    rst_n = 1'b0;
    instr = 32'd0;
    rd1   = 64'd0;
    rd2   = 64'd0;

    i_adds = {11'b10101011000, 5'd2, 6'd0, 5'd1, 5'd3};
    i_subs = {11'b11101011000, 5'd2, 6'd0, 5'd1, 5'd3};
    i_and  = {11'b10001010000, 5'd2, 6'd0, 5'd1, 5'd3};
    i_eor  = {11'b11001010000, 5'd2, 6'd0, 5'd1, 5'd3};
    i_addi = {10'b1001000100, 12'd100, 5'd1, 5'd2};
    i_blt  = {8'b01010100, 19'd4, 5'h0B};
    i_beq  = {8'b01010100, 19'd4, 5'h00};
    i_ldur = {11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd2};
    i_stur = {11'b11111000000, 9'h010, 2'b00, 5'd1, 5'd2};
    i_cbz  = {8'b10110100, 19'd2, 5'd3};
    i_b    = {6'b000101, 26'd3};
    i_lsr  = {11'b11010011010, 5'd0, 6'd4, 5'd1, 5'd2};
    c_adds = cv(1, 2'b00, 0, 1, 0, 0, 1, 0, 0, 3'b010);
    c_subs = cv(1, 2'b00, 0, 1, 0, 0, 1, 0, 0, 3'b011);

    apply(32'd0,  64'd0,  64'd0, 0, 0, mk(0,  13'd0, 64'd0, 4'b0100, 4'b0000));
    apply(i_adds, 64'd5,  64'd7, 1, 0, mk(1,  c_adds, 64'd12, 4'b0000, 4'b0000));
    apply(i_addi, 64'd5,  64'd0, 1, 0, mk(2,  cv(0, 2'b10, 0, 1, 0, 0, 0, 0, 0, 3'b010),
                                            64'd105, 4'b0000, 4'b0000));
    apply(i_adds, MAXP,   64'd1, 1, 0, mk(3,  c_adds, 64'h8000_0000_0000_0000, 4'b1010, 4'b0000));
    apply(i_and,  64'hF0F0, 64'hFF00, 1, 0, mk(4, cv(1, 2'b00, 0, 1, 0, 0, 0, 0, 0, 3'b100),
                                            64'hF000, 4'b0000, 4'b1010));
    apply(i_adds, ALL1,   64'd1, 1, 0, mk(5,  c_adds, 64'd0, 4'b0101, 4'b1010));
    apply(i_eor,  64'hFF, 64'h0F, 1, 0, mk(6, cv(1, 2'b00, 0, 1, 0, 0, 0, 0, 0, 3'b110),
                                            64'hF0, 4'b0000, 4'b0101));
    apply(i_blt,  64'd0,  64'd0, 1, 0, mk(7,  13'd0, 64'd0, 4'b0100, 4'b0101));
    apply(i_subs, 64'd3,  64'd5, 1, 0, mk(8,  c_subs, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 4'b0101));
    apply(i_blt,  64'd0,  64'd0, 1, 0, mk(9,  cv(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 3'b000),
                                            64'd0, 4'b0100, 4'b1000));
    apply(i_beq,  64'd0,  64'd0, 1, 0, mk(10, 13'd0, 64'd0, 4'b0100, 4'b1000));
    apply(i_ldur, 64'h100, 64'h55, 1, 0, mk(11, cv(0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 3'b010),
                                            64'hF8, 4'b0001, 4'b1000));
    apply(i_stur, 64'h200, 64'h55, 1, 0, mk(12, cv(0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 3'b010),
                                            64'h210, 4'b0000, 4'b1000));
    apply(i_cbz,  64'h77, 64'd0, 1, 0, mk(13, cv(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 3'b000),
                                            64'd0, 4'b0100, 4'b1000));
    apply(i_cbz,  64'h77, 64'd1, 1, 0, mk(14, 13'd0, 64'd1, 4'b0000, 4'b1000));
    apply(i_b,    64'd0,  64'd0, 1, 0, mk(15, cv(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 3'b000),
                                            64'd0, 4'b0100, 4'b1000));
    apply(i_lsr,  64'd0,  64'h30, 1, 0, mk(16, cv(0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 3'b000),
                                            64'h30, 4'b0000, 4'b1000));
    apply(ALL1[31:0], 64'd4, 64'd9, 1, 0, mk(17, 13'd0, 64'd9, 4'b0000, 4'b1000));
    // Reset dropped mid-cycle must clear flags before the next edge and hold them through a SUBS.
    apply(32'd0,  64'd0,  64'd0, 1, 1, mk(18, 13'd0, 64'd0, 4'b0100, 4'b0000));
    apply(i_subs, 64'd3,  64'd5, 0, 0, mk(19, c_subs, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 4'b0000));
    apply(32'd0,  64'd0,  64'd0, 0, 0, mk(20, 13'd0, 64'd0, 4'b0100, 4'b0000));
    apply(i_subs, 64'd3,  64'd5, 1, 0, mk(21, c_subs, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 4'b0000));
    apply(32'd0,  64'd0,  64'd0, 1, 0, mk(22, 13'd0, 64'd0, 4'b0100, 4'b1000));

    @(posedge clk);
    #1;
    chk_vld = 1'b0;
    for (int k = 0; k < 10 && n_pop != n_push; k++) @(posedge clk);
    n_checks++;
    if (n_pop != n_push || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d popped expected %0d", n_pop, n_push);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
